// File: rtl/peripheral_irq_requester_pkg.sv
// Shared definitions for the PIC peripheral request blocks.
package peripheral_irq_requester_pkg;

  // Request FSM encoding (kept as plain constants so older blocks can reuse it).
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ASSERT = 2'd1;
  localparam logic [1:0] ST_REARM  = 2'd2;

  // Width needed to count 0..v-1, never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/peripheral_irq_requester_sat_updown_counter.sv
// Saturating up/down counter for the pending-request queue.
module sat_updown_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  input  logic         dec_i,
  input  logic         clr_i,
  output logic [W-1:0] count_o,
  output logic [W-1:0] count_nxt_c,
  output logic         sat_hit_c
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear wins, simultaneous inc/dec cancel, hold at both ends.
  always_comb begin
    count_d   = count_q;
    sat_hit_c = 1'b0;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && !dec_i) begin
      if (count_q == CNT_MAX) begin
        sat_hit_c = 1'b1;
      end else begin
        count_d = count_q + W'(1);
      end
    end else if (dec_i && !inc_i && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o     = count_q;
  assign count_nxt_c = count_d;

endmodule

// File: rtl/peripheral_irq_requester.sv
// Turns peripheral event edges into a counted queue of 8259A IRn requests.
module peripheral_irq_requester
  import peripheral_irq_requester_pkg::*;
#(
  parameter int unsigned CNT_W          = 4,
  parameter int unsigned REARM_CYCLES   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             event_in,
  input  logic             level_mode,
  input  logic             ack,
  input  logic             clr,
  output logic             ir,
  output logic [CNT_W-1:0] pending_count,
  output logic             overflow,
  output logic             timeout_err
);

  localparam int unsigned RARM_W = clog2_min1(REARM_CYCLES);
  localparam int unsigned TMO_W  = clog2_min1(TIMEOUT_CYCLES);
  localparam logic [RARM_W-1:0] RARM_LAST = RARM_W'(REARM_CYCLES - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  =
    TMO_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
  localparam logic TMO_EN = (TIMEOUT_CYCLES > 0);

  logic [1:0]        state_q, state_d;
  logic              ir_q, ir_d;
  logic              event_prev_q;
  logic [RARM_W-1:0] rearm_q, rearm_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              overflow_q, overflow_d;
  logic              timeout_err_q, timeout_err_d;

  logic             inc_c;
  logic             ack_acc_c;
  logic             tmo_exp_c;
  logic             tmo_set_c;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt_c;
  logic             sat_hit_c;

  // Rising-edge detect; clr drops the event of its cycle.
  assign inc_c     = event_in & ~event_prev_q & ~clr;
  // Ack only counts while a request is actually on the wire.
  assign ack_acc_c = ack & (state_q == ST_ASSERT) & ~clr;
  // Expiry loses to an ack on the same cycle.
  assign tmo_exp_c = TMO_EN & (state_q == ST_ASSERT) & ~ack & (tmo_q == TMO_LAST);

  sat_updown_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk         (clk),
    .rst_n       (rst_n),
    .inc_i       (inc_c),
    .dec_i       (ack_acc_c),
    .clr_i       (clr),
    .count_o     (count),
    .count_nxt_c (count_nxt_c),
    .sat_hit_c   (sat_hit_c)
  );

  // Request FSM, timers and sticky flag next-state.
  always_comb begin
    state_d   = state_q;
    tmo_set_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!clr && (count != '0)) state_d = ST_ASSERT;
      end
      ST_ASSERT: begin
        if (clr) begin
          state_d = ST_REARM;
        end else if (ack_acc_c) begin
          if (level_mode) state_d = (count_nxt_c != '0) ? ST_ASSERT : ST_IDLE;
          else            state_d = ST_REARM;
        end else if (tmo_exp_c) begin
          state_d   = ST_REARM;
          tmo_set_c = 1'b1;
        end
      end
      ST_REARM: begin
        if (rearm_q == RARM_LAST) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    ir_d = (state_d == ST_ASSERT);

    rearm_d = '0;
    if ((state_q == ST_REARM) && (state_d == ST_REARM)) rearm_d = rearm_q + RARM_W'(1);

    tmo_d = '0;
    if ((state_q == ST_ASSERT) && (state_d == ST_ASSERT) && !ack_acc_c) tmo_d = tmo_q + TMO_W'(1);

    overflow_d    = clr ? 1'b0 : (overflow_q | sat_hit_c);
    timeout_err_d = clr ? 1'b0 : (timeout_err_q | tmo_set_c);
  end

  // State, timers, flags and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      ir_q          <= 1'b0;
      event_prev_q  <= 1'b1;
      rearm_q       <= '0;
      tmo_q         <= '0;
      overflow_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ir_q          <= ir_d;
      event_prev_q  <= event_in;
      rearm_q       <= rearm_d;
      tmo_q         <= tmo_d;
      overflow_q    <= overflow_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign ir            = ir_q;
  assign pending_count = count;
  assign overflow      = overflow_q;
  assign timeout_err   = timeout_err_q;

endmodule
